// File: rtl/tpram_model.sv
// -----------------------------------------------------------------------------
// tpram_model
//
// Behavioural two-port (one write port, one read port) RAM used in place of a
// vendor SRAM when checking memory-interface read paths.
//
// Features:
//   * byte write enables
//   * fully pipelined read path with RD_LATENCY stages (1..8)
//   * selectable same-address write/read collision behaviour
//   * per-read error injection (data flip, corrected, double error)
//   * tracking of never-written bytes, flagged on the read that returns them
//
// Parameters:
//   ADDR_WIDTH      address bits, depth = 2**ADDR_WIDTH words
//   DATA_WIDTH      word width, multiple of 8
//   RD_LATENCY      cycles from rd_en sample to rd_valid, 1..8
//   COLLISION_MODE  0 = read-old, 1 = read-new, 2 = X on colliding written bytes
//
// Ports:
//   clk        clock, everything happens on posedge
//   rst        synchronous active-high reset (read pipeline and outputs only)
//   clear      marks every byte unwritten
//   wr_en      write request
//   wr_addr    write address
//   wr_be      byte enables, bit i writes wr_data[8i+7:8i]
//   wr_data    write data
//   rd_en      read request
//   rd_addr    read address
//   inj_flip   with rd_en: returned word is bitwise inverted
//   inj_corr   with rd_en: ecccorr asserted with that read
//   inj_derr   with rd_en: eccderr asserted with that read (wins over inj_corr)
//   rd_valid   one-cycle pulse per read, RD_LATENCY cycles after rd_en
//   rd_data    read data, holds its value between rd_valid pulses
//   rd_uninit  with rd_valid: at least one returned byte was never written
//   ecccorr    with rd_valid: corrected-error indication
//   eccderr    with rd_valid: double-error indication
//
// Handshake: there is no back-pressure. A read is accepted on every posedge
// where rd_en=1 and rst=0, and exactly one rd_valid pulse follows RD_LATENCY
// cycles later unless rst is asserted while it is in flight, in which case it
// is dropped silently.
// -----------------------------------------------------------------------------
module tpram_model #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int RD_LATENCY     = 1,
    parameter int COLLISION_MODE = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    input  logic                    inj_flip,
    input  logic                    inj_corr,
    input  logic                    inj_derr,
    output logic                    rd_valid,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_uninit,
    output logic                    ecccorr,
    output logic                    eccderr
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int NB    = DATA_WIDTH / 8;

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    generate
        if (RD_LATENCY < 1 || RD_LATENCY > 8) begin : g_bad_latency
            $error("tpram_model: RD_LATENCY must be in 1..8");
        end
        if (DATA_WIDTH % 8 != 0) begin : g_bad_width
            $error("tpram_model: DATA_WIDTH must be a multiple of 8");
        end
        if (COLLISION_MODE < 0 || COLLISION_MODE > 2) begin : g_bad_mode
            $error("tpram_model: COLLISION_MODE must be 0, 1 or 2");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Storage: data array plus a per-byte written map.
    // Neither is touched by rst; only clear changes the map.
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem  [DEPTH];
    logic [NB-1:0]         wmap [DEPTH];

    logic wr_fire;
    logic rd_fire;

    assign wr_fire = wr_en && !rst;
    assign rd_fire = rd_en && !rst;

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) begin
                    mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    // clear wipes the whole map first; a write on the same edge then marks
    // its own bytes, discarding the pre-clear state of that word as well.
    always_ff @(posedge clk) begin
        if (clear) begin
            for (int a = 0; a < DEPTH; a++) begin
                wmap[a] <= '0;
            end
        end
        if (wr_fire) begin
            wmap[wr_addr] <= (clear ? '0 : wmap[wr_addr]) | wr_be;
        end
    end

    // ------------------------------------------------------------------
    // Read resolution at the sample edge. Everything a read returns is
    // decided here from the pre-edge array state, so later writes cannot
    // reach a read that is already in the pipeline.
    // ------------------------------------------------------------------
    logic                  collide;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [NB-1:0]         rd_unw;

    assign collide = wr_en && rd_en && (wr_addr == rd_addr);

    always_comb begin
        rd_word = mem[rd_addr];
        rd_unw  = ~wmap[rd_addr];
        for (int i = 0; i < NB; i++) begin
            if (rd_unw[i]) begin
                rd_word[8*i +: 8] = 'x;
            end
            // Only bytes actually being written collide; the rest keep the
            // old value. In mode 2 the byte is poisoned but its uninit flag
            // still reflects the old written state.
            if (collide && wr_be[i]) begin
                if (COLLISION_MODE == 1) begin
                    rd_word[8*i +: 8] = wr_data[8*i +: 8];
                    rd_unw[i]         = 1'b0;
                end else if (COLLISION_MODE == 2) begin
                    rd_word[8*i +: 8] = 'x;
                end
            end
        end
        if (inj_flip) begin
            rd_word = ~rd_word;
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline: RD_LATENCY stages, the last one drives the outputs.
    // Data registers only load behind a valid request so the final stage
    // holds the last returned word between pulses. Flags are stored
    // pre-qualified by valid so they read 0 whenever rd_valid is 0.
    // ------------------------------------------------------------------
    logic [RD_LATENCY-1:0] pv;
    logic [RD_LATENCY-1:0] pu;
    logic [RD_LATENCY-1:0] pc;
    logic [RD_LATENCY-1:0] pe;
    logic [DATA_WIDTH-1:0] pd [RD_LATENCY];

    always_ff @(posedge clk) begin
        if (rst) begin
            pv <= '0;
            pu <= '0;
            pc <= '0;
            pe <= '0;
            for (int k = 0; k < RD_LATENCY; k++) begin
                pd[k] <= '0;
            end
        end else begin
            pv[0] <= rd_fire;
            pu[0] <= rd_fire && (|rd_unw);
            pc[0] <= rd_fire && inj_corr && !inj_derr;
            pe[0] <= rd_fire && inj_derr;
            if (rd_fire) begin
                pd[0] <= rd_word;
            end
            for (int k = 1; k < RD_LATENCY; k++) begin
                pv[k] <= pv[k-1];
                pu[k] <= pu[k-1];
                pc[k] <= pc[k-1];
                pe[k] <= pe[k-1];
                if (pv[k-1]) begin
                    pd[k] <= pd[k-1];
                end
            end
        end
    end

    assign rd_valid  = pv[RD_LATENCY-1];
    assign rd_uninit = pu[RD_LATENCY-1];
    assign ecccorr   = pc[RD_LATENCY-1];
    assign eccderr   = pe[RD_LATENCY-1];
    assign rd_data   = pd[RD_LATENCY-1];

endmodule

// File: tb/tb_tpram_model.sv
// -----------------------------------------------------------------------------
// tb_tpram_model
//
// Three tpram_model instances share one stimulus stream:
//   u0: RD_LATENCY=3, read-old collisions
//   u1: RD_LATENCY=4, read-new collisions
//   u2: RD_LATENCY=1, X collisions
// A byte-level reference memory predicts every read; expected responses are
// queued with the cycle they are due and compared on the falling edge.
// Bytes the model cannot predict (never written, or poisoned by a collision)
// are masked out of the data comparison.
// -----------------------------------------------------------------------------
module tb_tpram_model;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int NB = DW / 8;
    localparam int NI = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          clear;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [NB-1:0] wr_be;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          inj_flip;
    logic          inj_corr;
    logic          inj_derr;

    logic [NI-1:0]         rv;
    logic [NI-1:0]         ru;
    logic [NI-1:0]         rc;
    logic [NI-1:0]         re;
    logic [NI-1:0][DW-1:0] rdat;

    tpram_model #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(3), .COLLISION_MODE(0)) u0 (
        .clk(clk), .rst(rst), .clear(clear),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .inj_flip(inj_flip), .inj_corr(inj_corr), .inj_derr(inj_derr),
        .rd_valid(rv[0]), .rd_data(rdat[0]), .rd_uninit(ru[0]),
        .ecccorr(rc[0]), .eccderr(re[0])
    );

    tpram_model #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(4), .COLLISION_MODE(1)) u1 (
        .clk(clk), .rst(rst), .clear(clear),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .inj_flip(inj_flip), .inj_corr(inj_corr), .inj_derr(inj_derr),
        .rd_valid(rv[1]), .rd_data(rdat[1]), .rd_uninit(ru[1]),
        .ecccorr(rc[1]), .eccderr(re[1])
    );

    tpram_model #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1), .COLLISION_MODE(2)) u2 (
        .clk(clk), .rst(rst), .clear(clear),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .inj_flip(inj_flip), .inj_corr(inj_corr), .inj_derr(inj_derr),
        .rd_valid(rv[2]), .rd_data(rdat[2]), .rd_uninit(ru[2]),
        .ecccorr(rc[2]), .eccderr(re[2])
    );

    // ---------------- reference model ----------------
    typedef struct {
        int          inst;
        int          due;
        logic [31:0] data;
        logic [31:0] mask;
        logic        uninit;
        logic        corr;
        logic        derr;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  ref_mem [256][NB];
    bit          ref_wr  [256][NB];
    logic [31:0] last_data [NI];
    logic [31:0] last_mask [NI];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    function automatic int lat_of(int i);
        return (i == 0) ? 3 : (i == 1) ? 4 : 1;
    endfunction

    function automatic int mode_of(int i);
        return i;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s @cyc %0d: observed %h expected %h", tag, cyc, got, exp);
        end
    endtask

    // Apply the currently driven inputs to the model, as the coming edge will.
    task automatic model_edge();
        exp_t e;
        bit   col;
        if (rst) begin
            exp_q.delete();
            for (int i = 0; i < NI; i++) begin
                last_data[i] = '0;
                last_mask[i] = '1;
            end
        end else if (rd_en) begin
            for (int i = 0; i < NI; i++) begin
                e.inst   = i;
                e.due    = cyc + lat_of(i);
                e.data   = '0;
                e.mask   = '0;
                e.uninit = 1'b0;
                for (int b = 0; b < NB; b++) begin
                    col = wr_en && (wr_addr == rd_addr) && wr_be[b];
                    if (col && mode_of(i) == 1) begin
                        e.data[8*b +: 8] = wr_data[8*b +: 8];
                        e.mask[8*b +: 8] = 8'hFF;
                    end else begin
                        if (!ref_wr[rd_addr][b]) e.uninit = 1'b1;
                        if (ref_wr[rd_addr][b] && !(col && mode_of(i) == 2)) begin
                            e.data[8*b +: 8] = ref_mem[rd_addr][b];
                            e.mask[8*b +: 8] = 8'hFF;
                        end
                    end
                end
                if (inj_flip) e.data = ~e.data;
                e.derr = inj_derr;
                e.corr = inj_corr && !inj_derr;
                exp_q.push_back(e);
            end
        end
        if (clear) begin
            for (int a = 0; a < 256; a++)
                for (int b = 0; b < NB; b++) ref_wr[a][b] = 1'b0;
        end
        if (wr_en && !rst) begin
            for (int b = 0; b < NB; b++) begin
                if (wr_be[b]) begin
                    ref_mem[wr_addr][b] = wr_data[8*b +: 8];
                    ref_wr[wr_addr][b]  = 1'b1;
                end
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic check_outputs();
        int   idx;
        exp_t e;
        for (int i = 0; i < NI; i++) begin
            idx = -1;
            for (int k = 0; k < exp_q.size(); k++) begin
                if (idx < 0 && exp_q[k].inst == i) idx = k;
            end
            if (idx >= 0 && exp_q[idx].due == cyc) begin
                e = exp_q[idx];
                exp_q.delete(idx);
                chk($sformatf("u%0d.rd_valid", i), 32'(rv[i]), 32'd1);
                chk($sformatf("u%0d.rd_data", i), rdat[i] & e.mask, e.data & e.mask);
                chk($sformatf("u%0d.rd_uninit", i), 32'(ru[i]), 32'(e.uninit));
                chk($sformatf("u%0d.ecccorr", i), 32'(rc[i]), 32'(e.corr));
                chk($sformatf("u%0d.eccderr", i), 32'(re[i]), 32'(e.derr));
                last_data[i] = e.data;
                last_mask[i] = e.mask;
            end else begin
                chk($sformatf("u%0d.rd_valid_idle", i), 32'(rv[i]), 32'd0);
                chk($sformatf("u%0d.rd_data_hold", i), rdat[i] & last_mask[i],
                    last_data[i] & last_mask[i]);
                chk($sformatf("u%0d.flags_idle", i), {29'd0, ru[i], rc[i], re[i]}, 32'd0);
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        model_edge();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle();
        rst = 0; clear = 0; wr_en = 0; wr_addr = '0; wr_be = '0; wr_data = '0;
        rd_en = 0; rd_addr = '0; inj_flip = 0; inj_corr = 0; inj_derr = 0;
    endtask

    task automatic set_wr(input logic [AW-1:0] a, input logic [NB-1:0] be, input logic [DW-1:0] d);
        wr_en = 1; wr_addr = a; wr_be = be; wr_data = d;
    endtask

    task automatic set_rd(input logic [AW-1:0] a, input logic f, input logic c, input logic d);
        rd_en = 1; rd_addr = a; inj_flip = f; inj_corr = c; inj_derr = d;
    endtask

    task automatic idle_ticks(input int n);
        for (int k = 0; k < n; k++) begin
            idle();
            tick();
        end
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        for (int i = 0; i < NI; i++) begin
            last_data[i] = '0;
            last_mask[i] = '1;
        end
        for (int a = 0; a < 256; a++)
            for (int b = 0; b < NB; b++) begin
                ref_mem[a][b] = 8'h00;
                ref_wr[a][b]  = 1'b0;
            end

        // Reset and initial clear of the written map
        idle(); rst = 1; clear = 1; tick();
        idle(); rst = 1; tick();
        idle_ticks(2);

        // T1: full-word write then read, latency per instance
        idle(); set_wr(8'h05, 4'hF, 32'h11223344); tick();
        idle(); set_rd(8'h05, 0, 0, 0); tick();
        idle_ticks(5);

        // T2: partial write after clear returns unwritten upper bytes
        idle(); clear = 1; tick();
        idle(); set_wr(8'h10, 4'b0011, 32'hAABBCCDD); tick();
        idle(); set_rd(8'h10, 0, 0, 0); tick();
        idle_ticks(5);

        // clear + write + read on one edge: read sees pre-clear state
        idle(); set_wr(8'h05, 4'hF, 32'h11223344); tick();
        idle(); clear = 1; set_wr(8'h30, 4'b1100, 32'h5566_7788); set_rd(8'h05, 0, 0, 0); tick();
        idle(); set_rd(8'h30, 0, 0, 0); tick();
        idle(); set_rd(8'h05, 0, 0, 0); tick();
        idle_ticks(5);

        // T3: back-to-back reads
        idle(); set_wr(8'h01, 4'hF, 32'h0101_A001); tick();
        idle(); set_wr(8'h02, 4'hF, 32'h0202_B002); tick();
        idle(); set_wr(8'h03, 4'hF, 32'h0303_C003); tick();
        for (int k = 1; k <= 3; k++) begin
            idle(); set_rd(AW'(k), 0, 0, 0); tick();
        end
        idle_ticks(5);

        // T4: same-edge collision, full word then partial byte enables
        idle(); set_wr(8'h20, 4'hF, 32'h0000_0000); tick();
        idle(); set_wr(8'h20, 4'hF, 32'hFFFF_FFFF); set_rd(8'h20, 0, 0, 0); tick();
        idle(); set_rd(8'h20, 0, 0, 0); tick();
        idle(); set_wr(8'h20, 4'b0101, 32'h1234_5678); set_rd(8'h20, 0, 0, 0); tick();
        idle_ticks(5);

        // T5: injection priority, then a clean read
        idle(); set_wr(8'h40, 4'hF, 32'h0000_FFFF); tick();
        idle(); set_rd(8'h40, 1, 1, 1); tick();
        idle(); set_rd(8'h40, 0, 0, 0); tick();
        idle(); set_rd(8'h40, 0, 1, 0); tick();
        idle_ticks(5);

        // T6: reset discards in-flight reads, and a read during rst
        idle(); set_rd(8'h01, 0, 0, 0); tick();
        idle(); set_rd(8'h02, 0, 1, 0); tick();
        idle(); set_wr(8'h50, 4'hF, 32'hDEAD_BEEF); tick();
        idle(); rst = 1; set_rd(8'h03, 0, 0, 0); tick();
        idle(); set_rd(8'h03, 0, 0, 0); tick();
        idle(); set_rd(8'h50, 0, 0, 0); tick();
        idle_ticks(6);

        // Random traffic on a small address window to force collisions
        for (int n = 0; n < 400; n++) begin
            idle();
            rst      = ($urandom_range(0, 63) == 0);
            clear    = ($urandom_range(0, 39) == 0);
            wr_en    = $urandom_range(0, 1);
            wr_addr  = AW'($urandom_range(0, 15));
            wr_be    = NB'($urandom_range(0, 15));
            wr_data  = $urandom;
            rd_en    = ($urandom_range(0, 2) != 0);
            rd_addr  = AW'($urandom_range(0, 15));
            inj_flip = ($urandom_range(0, 5) == 0);
            inj_corr = ($urandom_range(0, 5) == 0);
            inj_derr = ($urandom_range(0, 7) == 0);
            tick();
        end
        idle_ticks(8);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
